// File: rtl/sap3_pkg.sv
// SAP-3 shared types and sizing for the memory stage.
// Loader FSM states plus default RAM address width and bus width.
package sap3_pkg;

    typedef enum logic [1:0] {
        RUN,
        LOAD,
        DONE
    } mem_state_t;

    localparam int MEM_ADDR_W = 8;
    localparam int MAR_W      = 16;

endpackage

// File: rtl/mem_ram.sv
// SAP-3 byte RAM: async read at the CPU address, sync write.
// sel_ld hands the write port to the program loader.
module mem_ram
    import sap3_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              sel_ld,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_data,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [7:0]        rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;

    assign we    = sel_ld ? ld_we   : cpu_we;
    assign waddr = sel_ld ? ld_addr : cpu_addr;
    assign wdata = sel_ld ? ld_data : cpu_data;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data = mem[cpu_addr];

endmodule

// File: rtl/mem_unit.sv
// SAP-3 memory stage: MAR, byte RAM and program loader holding the core.
// Define MEM_LOAD_CHECKSUM_EN to add the ld_csum output.
module mem_unit
    import sap3_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int MAR_W  = sap3_pkg::MAR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MAR_W-1:0] bus,
    input  logic             mar_we,
    input  logic             ram_we,
    output logic [7:0]       mem_out,
    input  logic             ld_start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    output logic             ld_done,
    output logic             ld_ovf,
`ifdef MEM_LOAD_CHECKSUM_EN
    output logic [7:0]       ld_csum,
`endif
    output logic             cpu_hold
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic [MAR_W-1:0]  mar;
    logic [ADDR_W:0]   ld_addr;
    logic [7:0]        rd_data;
    logic              in_range;
    logic              accept;
    logic              at_end;
    logic              start;

    assign in_range = (mar[MAR_W-1:ADDR_W] == '0);
    assign cpu_hold = (state != RUN);
    assign ld_ready = (state == LOAD);
    assign ld_done  = (state == DONE);
    assign accept   = ld_valid && ld_ready;
    assign at_end   = (ld_addr == LAST_ADDR);
    assign start    = (state == RUN) && ld_start;
    assign mem_out  = in_range ? rd_data : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (ld_start) state_nxt = LOAD;
            LOAD:    if (accept && (ld_last || at_end)) state_nxt = DONE;
            DONE:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mar <= '0;
        end else if (mar_we && !cpu_hold) begin
            mar <= bus;
        end
    end

    // Overflow only when the final slot is filled and the image still continues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_addr <= '0;
            ld_ovf  <= 1'b0;
        end else if (start) begin
            ld_addr <= '0;
            ld_ovf  <= 1'b0;
        end else if (accept) begin
            ld_addr <= ld_addr + 1'b1;
            if (at_end && !ld_last) begin
                ld_ovf <= 1'b1;
            end
        end
    end

`ifdef MEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_csum <= 8'h00;
        end else if (start) begin
            ld_csum <= 8'h00;
        end else if (accept) begin
            ld_csum <= ld_csum + ld_data;
        end
    end
`endif

    mem_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk     (clk),
        .sel_ld  (cpu_hold),
        .cpu_we  (ram_we && in_range),
        .cpu_addr(mar[ADDR_W-1:0]),
        .cpu_data(bus[7:0]),
        .ld_we   (accept),
        .ld_addr (ld_addr[ADDR_W-1:0]),
        .ld_data (ld_data),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit against a memory-image reference model.
// Build with MEM_LOAD_CHECKSUM_EN to also check ld_csum.
module tb_mem_unit;

    logic        clk;
    logic        rst;
    logic [15:0] bus;
    logic        mar_we;
    logic        ram_we;
    logic [7:0]  mem_out;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_done;
    logic        ld_ovf;
    logic        cpu_hold;
`ifdef MEM_LOAD_CHECKSUM_EN
    logic [7:0]  ld_csum;
`endif

    mem_unit dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .mar_we  (mar_we),
        .ram_we  (ram_we),
        .mem_out (mem_out),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data (ld_data),
        .ld_last (ld_last),
        .ld_done (ld_done),
        .ld_ovf  (ld_ovf),
`ifdef MEM_LOAD_CHECKSUM_EN
        .ld_csum (ld_csum),
`endif
        .cpu_hold(cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    logic [7:0]  ref_mem [256];
    logic [15:0] ref_mar;
    bit          ref_hold;
    logic [7:0]  ld_q [$];

    function automatic logic [7:0] ref_read();
        return (ref_mar[15:8] == 8'h00) ? ref_mem[ref_mar[7:0]] : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU cycle; the model applies write-before-MAR-update ordering.
    task automatic cpu_op(input bit mw, input bit rw, input logic [15:0] b);
        mar_we = mw;
        ram_we = rw;
        bus    = b;
        tick();
        if (!ref_hold) begin
            if (rw && ref_mar[15:8] == 8'h00) ref_mem[ref_mar[7:0]] = b[7:0];
            if (mw) ref_mar = b;
        end
        mar_we = 1'b0;
        ram_we = 1'b0;
    endtask

    task automatic readback(input string nm, input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            cpu_op(1'b1, 1'b0, 16'(a));
            n_checks++;
            if (mem_out !== ref_read()) begin
                n_fail++;
                $display("FAIL %s addr=%0d got=%h exp=%h", nm, a, mem_out, ref_read());
            end
        end
    endtask

    // mode: 0 always valid, 1 toggling valid, 2 random valid.
    task automatic run_load(input string nm, input bit use_last, input int mode);
        int  idx;
        int  cyc;
        bit  fin;
        bit  v;
        bit  ovf_exp;
        int  csum;
        int  n;
        n       = ld_q.size();
        idx     = 0;
        cyc     = 0;
        fin     = 0;
        ovf_exp = 0;
        csum    = 0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ref_hold = 1;
        while (!fin && cyc < 4000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            ld_start = (mode == 1 && cyc == 1);
            ld_valid = v;
            ld_data  = ld_q[idx];
            ld_last  = use_last && (idx == n - 1);
            n_checks++;
            if (ld_ready !== 1'b1 || ld_done !== 1'b0 || cpu_hold !== 1'b1 || ld_ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_load cyc=%0d rdy/done/hold/ovf=%b%b%b%b exp=1010",
                         nm, cyc, ld_ready, ld_done, cpu_hold, ld_ovf);
            end
            tick();
            if (v) begin
                ref_mem[idx] = ld_q[idx];
                csum += ld_q[idx];
                if (use_last && idx == n - 1) begin
                    fin = 1;
                end else if (idx == 255) begin
                    fin = 1;
                    ovf_exp = 1;
                end
                idx++;
            end
            cyc++;
        end
        ld_start = 1'b0;
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s_timeout got=%0d beats exp=%0d", nm, idx, n);
        end
        ld_last  = 1'b0;
        ld_valid = (idx < n);
        ld_data  = (idx < n) ? ld_q[idx] : 8'h00;
        n_checks++;
        if (ld_done !== 1'b1 || ld_ready !== 1'b0 || cpu_hold !== 1'b1 || ld_ovf !== ovf_exp) begin
            n_fail++;
            $display("FAIL %s_done done/rdy/hold/ovf=%b%b%b%b exp=101%b",
                     nm, ld_done, ld_ready, cpu_hold, ld_ovf, ovf_exp);
        end
`ifdef MEM_LOAD_CHECKSUM_EN
        n_checks++;
        if (ld_csum !== 8'(csum)) begin
            n_fail++;
            $display("FAIL %s_csum got=%h exp=%h", nm, ld_csum, 8'(csum));
        end
`endif
        tick();
        ref_hold = 0;
        n_checks++;
        if (ld_done !== 1'b0 || ld_ready !== 1'b0 || cpu_hold !== 1'b0 || ld_ovf !== ovf_exp) begin
            n_fail++;
            $display("FAIL %s_run done/rdy/hold/ovf=%b%b%b%b exp=000%b",
                     nm, ld_done, ld_ready, cpu_hold, ld_ovf, ovf_exp);
        end
        tick();
        ld_valid = 1'b0;
`ifdef MEM_LOAD_CHECKSUM_EN
        n_checks++;
        if (ld_csum !== 8'(csum)) begin
            n_fail++;
            $display("FAIL %s_csum_hold got=%h exp=%h", nm, ld_csum, 8'(csum));
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({ld_ready, ld_done, ld_ovf, cpu_hold} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold got=%b exp=0000", {ld_ready, ld_done, ld_ovf, cpu_hold});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        ref_mar = 16'h0000;
        n_checks++;
        if ({ld_ready, ld_done, ld_ovf, cpu_hold} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_rel got=%b exp=0000", {ld_ready, ld_done, ld_ovf, cpu_hold});
        end
    endtask

    task automatic test_fill();
        ld_q.delete();
        for (int i = 0; i < 256; i++) ld_q.push_back(8'($urandom));
        run_load("fill", 1'b1, 2);
        readback("fill_rb", 0, 255);
    endtask

    task automatic test_basic();
        cpu_op(1'b1, 1'b0, 16'h0005);
        n_checks++;
        if (mem_out !== ref_mem[5]) begin
            n_fail++;
            $display("FAIL basic_rd got=%h exp=%h", mem_out, ref_mem[5]);
        end
        cpu_op(1'b0, 1'b1, 16'h00A7);
        n_checks++;
        if (mem_out !== 8'hA7) begin
            n_fail++;
            $display("FAIL basic_wr got=%h exp=a7", mem_out);
        end
    endtask

    task automatic test_same_cycle();
        cpu_op(1'b1, 1'b0, 16'h0009);
        cpu_op(1'b0, 1'b1, 16'h005A);
        cpu_op(1'b1, 1'b0, 16'h0003);
        cpu_op(1'b1, 1'b1, 16'h0009);
        n_checks++;
        if (mem_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL same_ram9 got=%h exp=5a", mem_out);
        end
        cpu_op(1'b1, 1'b0, 16'h0003);
        n_checks++;
        if (mem_out !== 8'h09) begin
            n_fail++;
            $display("FAIL same_ram3 got=%h exp=09", mem_out);
        end
    endtask

    task automatic test_out_of_range();
        cpu_op(1'b1, 1'b0, 16'h0100);
        n_checks++;
        if (mem_out !== 8'h00) begin
            n_fail++;
            $display("FAIL oor_rd got=%h exp=00", mem_out);
        end
        cpu_op(1'b0, 1'b1, {8'h00, ~ref_mem[0]});
        cpu_op(1'b1, 1'b0, 16'h0000);
        n_checks++;
        if (mem_out !== ref_mem[0]) begin
            n_fail++;
            $display("FAIL oor_drop got=%h exp=%h", mem_out, ref_mem[0]);
        end
    endtask

    task automatic test_random_cpu();
        logic [15:0] b;
        for (int i = 0; i < 200; i++) begin
            b[7:0]  = 8'($urandom);
            b[15:8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cpu_op(1'($urandom), 1'($urandom), b);
            n_checks++;
            if (mem_out !== ref_read()) begin
                n_fail++;
                $display("FAIL rand_cpu i=%0d mar=%h got=%h exp=%h", i, ref_mar, mem_out, ref_read());
            end
        end
    endtask

    task automatic test_overflow();
        ld_q.delete();
        for (int i = 0; i < 257; i++) ld_q.push_back(8'($urandom));
        run_load("ovf", 1'b0, 0);
        readback("ovf_rb", 0, 255);
    endtask

    task automatic test_load_toggle();
        ld_q.delete();
        ld_q.push_back(8'h11);
        ld_q.push_back(8'h22);
        ld_q.push_back(8'h33);
        run_load("tog", 1'b1, 1);
        readback("tog_rb", 0, 4);
    endtask

    task automatic test_abort();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        b = 8'($urandom);
        cpu_op(1'b1, 1'b0, 16'h0010);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ref_hold = 1;
        ld_valid = 1'b1;
        ld_data  = a;
        ld_last  = 1'b0;
        tick();
        ref_mem[0] = a;
        ld_data = b;
        cpu_op(1'b1, 1'b1, 16'h00EE);
        ref_mem[1] = b;
        ld_data = 8'($urandom);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({cpu_hold, ld_ready, ld_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_rst got=%b exp=000", {cpu_hold, ld_ready, ld_done});
        end
        ld_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_mar  = 16'h0000;
        ref_hold = 0;
        tick();
        n_checks++;
        if (mem_out !== a) begin
            n_fail++;
            $display("FAIL abort_b0 got=%h exp=%h", mem_out, a);
        end
        readback("abort_rb", 0, 17);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ref_hold = 0;
        ref_mar  = 16'h0000;
        rst      = 1'b1;
        bus      = 16'h0000;
        mar_we   = 1'b0;
        ram_we   = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;
        test_reset();
        test_fill();
        test_basic();
        test_same_cycle();
        test_out_of_range();
        test_random_cpu();
        test_overflow();
        test_load_toggle();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
